// File: rtl/vr_sweep_ctrl_if.sv
// Host/test-controller and logic-unit signals for the exhaustive-sweep sequencer.
// The controller is the slave; the host plus the logic unit form the master side.
interface vr_sweep_ctrl_if;
    localparam int unsigned IDX_I_W = 4;
    localparam int unsigned MODE_W  = 2;
    localparam int unsigned RES_W   = 64;
    localparam int unsigned ONES_W  = 7;

    logic                start;
    logic                abort;
    logic                busy;
    logic                done;
    logic [RES_W-1:0]    result;
    logic [ONES_W-1:0]   ones_count;
    logic [IDX_I_W-1:0]  dut_I;
    logic [MODE_W-1:0]   dut_mode;
    logic                dut_O;

    modport master (
        output start, abort, dut_O,
        input  busy, done, result, ones_count, dut_I, dut_mode
    );

    modport slave (
        input  start, abort, dut_O,
        output busy, done, result, ones_count, dut_I, dut_mode
    );
endinterface

// File: rtl/vr_sweep_ctrl.sv
// Walks all 64 {mode, I} vectors of the logic unit, holds each for SETTLE cycles,
// then captures the unit output into a result vector with a running ones count.
module vr_sweep_ctrl #(
    parameter int unsigned SETTLE = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    vr_sweep_ctrl_if.slave  bus
);
    localparam int unsigned IDX_W  = 6;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned RES_W  = 64;
    localparam int unsigned ONES_W = 7;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = '1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_SAMPLE,
        ST_DONE
    } state_e;

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [RES_W-1:0]    result_q, result_d;
    logic [ONES_W-1:0]   ones_q, ones_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            ones_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            ones_q   <= ones_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // Abort leaves idx/result/ones_count untouched so a partial capture stays readable.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        ones_d   = ones_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start && !bus.abort) begin
                    idx_d    = '0;
                    cnt_d    = '0;
                    result_d = '0;
                    ones_d   = '0;
                    state_d  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (bus.abort) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_SAMPLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_SAMPLE: begin
                if (bus.abort) begin
                    state_d = ST_IDLE;
                end else begin
                    result_d[idx_q] = bus.dut_O;
                    ones_d          = ones_q + ONES_W'(bus.dut_O);
                    if (idx_q == IDX_LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Registered status follows the state being entered.
        busy_d = (state_d == ST_WAIT) || (state_d == ST_SAMPLE);
        done_d = (state_d == ST_DONE);
    end

    assign bus.dut_I      = idx_q[3:0];
    assign bus.dut_mode   = idx_q[5:4];
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.result     = result_q;
    assign bus.ones_count = ones_q;

endmodule

// File: tb/tb_vr_sweep_ctrl.sv
// Scoreboard bench for vr_sweep_ctrl: SETTLE=1 and SETTLE=3 instances driven by stub logic units.
module tb_vr_sweep_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vr_sweep_ctrl_if if1 ();
    vr_sweep_ctrl_if if3 ();

    vr_sweep_ctrl #(.SETTLE(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
    vr_sweep_ctrl #(.SETTLE(3)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(if3.slave));

    typedef struct {
        logic [63:0] result;
        logic [6:0]  ones;
        int          cycles;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    int   stub_sel = 0;
    logic sel3     = 1'b0;
    logic start_t  = 1'b0;
    logic abort_t  = 1'b0;

    // Stub logic unit: 0 -> O = I[mode], 1 -> constant 1, otherwise constant 0
    function automatic logic stub_o(input int sel, input logic [5:0] idx);
        logic [3:0] i;
        logic [1:0] m;
        i = idx[3:0];
        m = idx[5:4];
        case (sel)
            0:       return i[m];
            1:       return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic exp_t model(input int sel, input int n_vec);
        exp_t e;
        e.result = '0;
        e.ones   = '0;
        e.cycles = 0;
        for (int k = 0; k < n_vec; k++) begin
            logic o;
            o = stub_o(sel, 6'(k));
            e.result[k] = o;
            e.ones      = e.ones + 7'(o);
        end
        return e;
    endfunction

    assign if1.start = start_t & ~sel3;
    assign if1.abort = abort_t & ~sel3;
    assign if3.start = start_t & sel3;
    assign if3.abort = abort_t & sel3;
    assign if1.dut_O = stub_o(stub_sel, {if1.dut_mode, if1.dut_I});
    assign if3.dut_O = stub_o(stub_sel, {if3.dut_mode, if3.dut_I});

    logic        m_busy, m_done;
    logic [63:0] m_result;
    logic [6:0]  m_ones;
    logic [5:0]  m_idx;
    assign m_busy   = sel3 ? if3.busy       : if1.busy;
    assign m_done   = sel3 ? if3.done       : if1.done;
    assign m_result = sel3 ? if3.result     : if1.result;
    assign m_ones   = sel3 ? if3.ones_count : if1.ones_count;
    assign m_idx    = sel3 ? {if3.dut_mode, if3.dut_I} : {if1.dut_mode, if1.dut_I};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic pop_exp(output exp_t e);
        if (sb.size() == 0) begin
            check("scoreboard_empty", 64'(0), 64'(1));
            e.result = '0;
            e.ones   = '0;
            e.cycles = 0;
        end else begin
            e = sb.pop_front();
        end
    endtask

    // Full sweep; restart_at >= 0 re-pulses start that many edges after acceptance
    task automatic run_sweep(input logic use3, input int sel, input int restart_at);
        int   s;
        int   edges;
        int   busy_cyc;
        int   vec_err;
        bit   seen_done;
        exp_t e;
        sel3     = use3;
        stub_sel = sel;
        s        = use3 ? 3 : 1;
        @(negedge clk);
        e        = model(sel, 64);
        e.cycles = 64 * (s + 1);
        sb.push_back(e);
        start_t = 1'b1;
        @(negedge clk);
        start_t   = 1'b0;
        edges     = 0;
        busy_cyc  = 0;
        vec_err   = 0;
        seen_done = 1'b0;
        check("result_cleared", m_result, 64'(0));
        check("ones_cleared", 64'(m_ones), 64'(0));
        while (!seen_done && edges < 2000) begin
            if (m_done) begin
                seen_done = 1'b1;
            end else begin
                if (m_busy) busy_cyc++;
                if (m_idx !== 6'(edges / (s + 1))) vec_err++;
                edges++;
                start_t = (edges == restart_at);
                @(negedge clk);
            end
        end
        start_t = 1'b0;
        check("done_seen", 64'(seen_done), 64'(1));
        pop_exp(e);
        check("sweep_cycles", 64'(edges), 64'(e.cycles));
        check("busy_cycles", 64'(busy_cyc), 64'(e.cycles));
        check("vec_order", 64'(vec_err), 64'(0));
        check("busy_at_done", 64'(m_busy), 64'(0));
        check("result", m_result, e.result);
        check("ones_count", 64'(m_ones), 64'(e.ones));
        @(negedge clk);
        check("done_pulse_width", 64'(m_done), 64'(0));
        check("result_held", m_result, e.result);
    endtask

    initial begin
        exp_t        e;
        int          n;
        int          done_hits;
        logic [63:0] r0;

        repeat (3) @(negedge clk);
        check("rst_busy", 64'({if1.busy, if3.busy}), 64'(0));
        check("rst_done", 64'({if1.done, if3.done}), 64'(0));
        check("rst_result", if1.result | if3.result, 64'(0));
        check("rst_ones", 64'({if1.ones_count, if3.ones_count}), 64'(0));
        check("rst_idx", 64'({if1.dut_mode, if1.dut_I, if3.dut_mode, if3.dut_I}), 64'(0));
        rst_n = 1'b1;

        run_sweep(1'b0, 0, -1);
        check("pattern_const", m_result, 64'hFF00_F0F0_CCCC_AAAA);
        check("pattern_ones", 64'(m_ones), 64'(32));
        run_sweep(1'b0, 1, -1);
        check("all_ones_const", m_result, '1);
        check("ones_64", 64'(m_ones), 64'(64));
        run_sweep(1'b0, 2, -1);
        check("all_zero_const", m_result, 64'(0));
        run_sweep(1'b1, 0, -1);
        check("settle3_const", m_result, 64'hFF00_F0F0_CCCC_AAAA);

        // Abort while vector 20 is being settled
        sel3 = 1'b0; stub_sel = 0;
        @(negedge clk); start_t = 1'b1;
        @(negedge clk); start_t = 1'b0;
        n = 0;
        while (m_idx != 6'd20 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("abort_reach_20", 64'(m_idx), 64'd20);
        e = model(0, 20);
        sb.push_back(e);
        abort_t = 1'b1;
        @(negedge clk);
        abort_t = 1'b0;
        pop_exp(e);
        check("abort_busy", 64'(m_busy), 64'(0));
        check("abort_result", m_result, e.result);
        check("abort_result_const", m_result, 64'hC_AAAA);
        check("abort_ones", 64'(m_ones), 64'(e.ones));
        check("abort_idx_held", 64'(m_idx), 64'd20);
        done_hits = 0;
        repeat (6) begin
            if (m_done) done_hits++;
            @(negedge clk);
        end
        check("abort_no_done", 64'(done_hits), 64'(0));
        check("abort_result_held", m_result, 64'hC_AAAA);

        run_sweep(1'b0, 0, 37);

        // Start and abort together in IDLE
        r0 = m_result;
        @(negedge clk); start_t = 1'b1; abort_t = 1'b1;
        @(negedge clk); start_t = 1'b0; abort_t = 1'b0;
        n = 0;
        repeat (4) begin
            if (m_busy) n++;
            @(negedge clk);
        end
        check("start_abort_idle", 64'(n), 64'(0));
        check("start_abort_result", m_result, r0);

        // Asynchronous reset between clock edges mid-sweep
        sel3 = 1'b0; stub_sel = 0;
        @(negedge clk); start_t = 1'b1;
        @(negedge clk); start_t = 1'b0;
        repeat (50) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", 64'(if1.busy), 64'(0));
        check("arst_done", 64'(if1.done), 64'(0));
        check("arst_result", if1.result, 64'(0));
        check("arst_ones", 64'(if1.ones_count), 64'(0));
        check("arst_idx", 64'({if1.dut_mode, if1.dut_I}), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        run_sweep(1'b0, 0, -1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
